// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: write-back has fixed priority, aux writes queue in a small FIFO,
// and a starved queue forces a one-cycle pipeline bubble.
module rf_write_arbiter #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned ADDR_LEN     = 5,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_wr_en,
   input  logic [ADDR_LEN-1:0] wb_addr,
   input  logic [WIDTH-1:0]    wb_data,
   input  logic [1:0]          wb_mode,
   input  logic                aux_valid,
   output logic                aux_ready,
   input  logic [ADDR_LEN-1:0] aux_addr,
   input  logic [WIDTH-1:0]    aux_data,
   input  logic [1:0]          aux_mode,
   output logic                pipe_stall,
   output logic                rf_wr_en,
   output logic [ADDR_LEN-1:0] rf_addr,
   output logic [WIDTH-1:0]    rf_data,
   output logic [1:0]          rf_mode,
   output logic                arb_err
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned ENT_W = 2 + ADDR_LEN + WIDTH;

   localparam logic [0:0] ST_ARB   = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;

   logic [ENT_W-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [STV_W-1:0]    starve_q, starve_d;
   logic [0:0]          state_q, state_d;
   logic                rf_wr_en_q, rf_wr_en_d;
   logic [ADDR_LEN-1:0] rf_addr_q, rf_addr_d;
   logic [WIDTH-1:0]    rf_data_q, rf_data_d;
   logic [1:0]          rf_mode_q, rf_mode_d;
   logic                pipe_stall_q, pipe_stall_d;
   logic                arb_err_q, arb_err_d;

   logic                empty, push, pop;
   logic [ADDR_LEN-1:0] head_addr;
   logic [WIDTH-1:0]    head_data;
   logic [1:0]          head_mode;

   assign empty     = (count_q == '0);
   assign aux_ready = ~rst & (count_q < CNT_W'(DEPTH));
   assign push      = aux_valid & aux_ready;
   assign pop       = ~wb_wr_en & ~empty;
   assign {head_mode, head_addr, head_data} = mem_q[rd_ptr_q];

   // Grant, FIFO bookkeeping, starvation tracking and bubble FSM.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      starve_d     = '0;
      state_d      = ST_ARB;
      rf_wr_en_d   = 1'b0;
      rf_addr_d    = rf_addr_q;
      rf_data_d    = rf_data_q;
      rf_mode_d    = rf_mode_q;
      arb_err_d    = arb_err_q;
      pipe_stall_d = 1'b0;

      if (wb_wr_en) begin
         rf_addr_d  = wb_addr;
         rf_data_d  = wb_data;
         rf_mode_d  = wb_mode;
         rf_wr_en_d = (wb_addr != '0);
      end else if (pop) begin
         rf_addr_d  = head_addr;
         rf_data_d  = head_data;
         rf_mode_d  = head_mode;
         rf_wr_en_d = (head_addr != '0);
      end

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      // Saturating so a blocked cycle right after a bubble cannot wrap the counter.
      if (~empty & wb_wr_en)
         starve_d = (starve_q < STV_W'(STARVE_LIMIT)) ? starve_q + STV_W'(1) : starve_q;

      case (state_q)
         ST_ARB: begin
            if (starve_d >= STV_W'(STARVE_LIMIT)) begin
               state_d  = ST_STALL;
               starve_d = '0;
            end
         end
         ST_STALL: begin
            state_d = ST_ARB;
            if (wb_wr_en) arb_err_d = 1'b1;
         end
         default: state_d = ST_ARB;
      endcase

      pipe_stall_d = (state_d == ST_STALL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         starve_q     <= '0;
         state_q      <= ST_ARB;
         rf_wr_en_q   <= 1'b0;
         rf_addr_q    <= '0;
         rf_data_q    <= '0;
         rf_mode_q    <= '0;
         pipe_stall_q <= 1'b0;
         arb_err_q    <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         starve_q     <= starve_d;
         state_q      <= state_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_addr_q    <= rf_addr_d;
         rf_data_q    <= rf_data_d;
         rf_mode_q    <= rf_mode_d;
         pipe_stall_q <= pipe_stall_d;
         arb_err_q    <= arb_err_d;
      end
   end

   // Storage needs no reset: entries are only read once counted in.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {aux_mode, aux_addr, aux_data};
   end

   assign rf_wr_en   = rf_wr_en_q;
   assign rf_addr    = rf_addr_q;
   assign rf_data    = rf_data_q;
   assign rf_mode    = rf_mode_q;
   assign pipe_stall = pipe_stall_q;
   assign arb_err    = arb_err_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios then randomized traffic, all cycles checked
// against a queue-based reference model.
module tb_rf_write_arbiter;

   localparam int unsigned WIDTH        = 32;
   localparam int unsigned ADDR_LEN     = 5;
   localparam int unsigned DEPTH        = 2;
   localparam int unsigned STARVE_LIMIT = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                wb_wr_en = 1'b0;
   logic [ADDR_LEN-1:0] wb_addr = '0;
   logic [WIDTH-1:0]    wb_data = '0;
   logic [1:0]          wb_mode = '0;
   logic                aux_valid = 1'b0;
   logic                aux_ready;
   logic [ADDR_LEN-1:0] aux_addr = '0;
   logic [WIDTH-1:0]    aux_data = '0;
   logic [1:0]          aux_mode = '0;
   logic                pipe_stall, rf_wr_en, arb_err;
   logic [ADDR_LEN-1:0] rf_addr;
   logic [WIDTH-1:0]    rf_data;
   logic [1:0]          rf_mode;

   always #5 clk = ~clk;

   rf_write_arbiter #(
      .WIDTH(WIDTH), .ADDR_LEN(ADDR_LEN), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_wr_en(wb_wr_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_mode(wb_mode),
      .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr),
      .aux_data(aux_data), .aux_mode(aux_mode),
      .pipe_stall(pipe_stall), .rf_wr_en(rf_wr_en), .rf_addr(rf_addr),
      .rf_data(rf_data), .rf_mode(rf_mode), .arb_err(arb_err)
   );

   typedef struct packed {
      logic [1:0]          mode;
      logic [ADDR_LEN-1:0] addr;
      logic [WIDTH-1:0]    data;
   } wr_t;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   wr_t                 q[$];
   logic                m_wr, m_stall, m_err;
   logic [ADDR_LEN-1:0] m_addr;
   logic [WIDTH-1:0]    m_data;
   logic [1:0]          m_mode;
   int                  m_starve;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_wr = 1'b0; m_stall = 1'b0; m_err = 1'b0;
      m_addr = '0; m_data = '0; m_mode = '0;
      m_starve = 0;
   endtask

   // One clock: compare outputs with the model, drive new inputs, advance the model.
   task automatic step(input logic r, input logic we, input logic [ADDR_LEN-1:0] wa,
                       input logic [WIDTH-1:0] wd, input logic [1:0] wm, input logic av,
                       input logic [ADDR_LEN-1:0] aa, input logic [WIDTH-1:0] ad,
                       input logic [1:0] am);
      logic rdy, nonempty, got_one;
      wr_t  g;
      @(negedge clk);
      check("rf_wr_en", 64'(rf_wr_en), 64'(m_wr));
      if (m_wr) begin
         check("rf_addr", 64'(rf_addr), 64'(m_addr));
         check("rf_data", 64'(rf_data), 64'(m_data));
         check("rf_mode", 64'(rf_mode), 64'(m_mode));
      end
      check("pipe_stall", 64'(pipe_stall), 64'(m_stall));
      check("arb_err", 64'(arb_err), 64'(m_err));
      check("aux_ready", 64'(aux_ready), 64'(!rst && (q.size() < DEPTH)));

      rst = r; wb_wr_en = we; wb_addr = wa; wb_data = wd; wb_mode = wm;
      aux_valid = av; aux_addr = aa; aux_data = ad; aux_mode = am;

      rdy = !r && (q.size() < DEPTH);
      if (r) begin
         model_reset();
      end else begin
         nonempty = (q.size() != 0);
         got_one  = 1'b0;
         g        = '0;
         if (m_stall && we) m_err = 1'b1;
         if (we) begin
            g = '{mode: wm, addr: wa, data: wd};
            got_one = 1'b1;
         end else if (nonempty) begin
            g = q.pop_front();
            got_one = 1'b1;
         end
         if (got_one) begin
            m_addr = g.addr; m_data = g.data; m_mode = g.mode;
         end
         m_wr = got_one && (g.addr != '0);
         m_starve = (nonempty && we) ? m_starve + 1 : 0;
         if (m_stall) begin
            m_stall = 1'b0;
         end else if (m_starve >= STARVE_LIMIT) begin
            m_stall  = 1'b1;
            m_starve = 0;
         end
         if (av && rdy) q.push_back('{mode: am, addr: aa, data: ad});
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ADDR_LEN-1:0] rand_addr();
      return ($urandom_range(0, 7) == 0) ? '0 : ADDR_LEN'($urandom_range(1, (1 << ADDR_LEN) - 1));
   endfunction

   initial begin
      model_reset();
      @(posedge clk);

      // Reset values, then WB-only write
      step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 1'b0, '0, '0, 2'd0);
      after_edge();
      check("t1_wr_en", 64'(rf_wr_en), 64'd1);
      check("t1_addr", 64'(rf_addr), 64'd5);
      check("t1_data", 64'(rf_data), 64'hDEADBEEF);

      // Aux write on an idle pipe lands two cycles after acceptance
      step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1, 5'd7, 32'h1234, 2'd1);
      after_edge();
      check("t2_wr_en_t1", 64'(rf_wr_en), 64'd0);
      idle();
      after_edge();
      check("t2_wr_en_t2", 64'(rf_wr_en), 64'd1);
      check("t2_addr", 64'(rf_addr), 64'd7);
      check("t2_mode", 64'(rf_mode), 64'd1);

      // Full FIFO back-pressure, then in-order drain
      step(1'b0, 1'b1, 5'd9, 32'h9, 2'd0, 1'b1, 5'd10, 32'hA0, 2'd0);
      step(1'b0, 1'b1, 5'd9, 32'h9, 2'd0, 1'b1, 5'd11, 32'hB0, 2'd2);
      after_edge();
      check("t3_ready_full", 64'(aux_ready), 64'd0);
      step(1'b0, 1'b1, 5'd9, 32'h9, 2'd0, 1'b1, 5'd12, 32'hC0, 2'd0);
      idle();
      after_edge();
      check("t3_first_addr", 64'(rf_addr), 64'd10);
      check("t3_ready_back", 64'(aux_ready), 64'd1);
      idle();
      after_edge();
      check("t3_second_addr", 64'(rf_addr), 64'd11);
      check("t3_second_data", 64'(rf_data), 64'hB0);
      idle();
      after_edge();
      check("t3_third_dropped", 64'(rf_wr_en), 64'd0);

      // Starvation bubble honoured, then violated
      step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1, 5'd20, 32'h20, 2'd0);
      repeat (STARVE_LIMIT) step(1'b0, 1'b1, 5'd3, 32'h3, 2'd0, 1'b0, '0, '0, 2'd0);
      after_edge();
      check("t4_stall", 64'(pipe_stall), 64'd1);
      idle();
      after_edge();
      check("t4_head_addr", 64'(rf_addr), 64'd20);
      check("t4_stall_clr", 64'(pipe_stall), 64'd0);
      check("t4_no_err", 64'(arb_err), 64'd0);
      step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1, 5'd21, 32'h21, 2'd0);
      repeat (STARVE_LIMIT) step(1'b0, 1'b1, 5'd3, 32'h3, 2'd0, 1'b0, '0, '0, 2'd0);
      step(1'b0, 1'b1, 5'd4, 32'h4, 2'd0, 1'b0, '0, '0, 2'd0);
      after_edge();
      check("t4_err", 64'(arb_err), 64'd1);
      check("t4_wb_wins", 64'(rf_addr), 64'd4);
      idle();

      // Register 0 writes are suppressed but still consumed
      step(1'b0, 1'b1, 5'd0, 32'hFFFF, 2'd0, 1'b1, 5'd0, 32'h55, 2'd0);
      after_edge();
      check("t5_wb_r0", 64'(rf_wr_en), 64'd0);
      step(1'b0, 1'b1, 5'd6, 32'h6, 2'd0, 1'b1, 5'd13, 32'h13, 2'd0);
      idle();
      after_edge();
      check("t5_aux_r0", 64'(rf_wr_en), 64'd0);
      check("t5_ready", 64'(aux_ready), 64'd1);
      idle();

      // Reset mid-operation
      step(1'b0, 1'b1, 5'd8, 32'h8, 2'd0, 1'b1, 5'd14, 32'h14, 2'd0);
      step(1'b0, 1'b1, 5'd8, 32'h8, 2'd0, 1'b1, 5'd15, 32'h15, 2'd0);
      step(1'b1, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0);
      after_edge();
      check("t6_wr_en", 64'(rf_wr_en), 64'd0);
      check("t6_data", 64'(rf_data), 64'd0);
      check("t6_err", 64'(arb_err), 64'd0);
      check("t6_ready_in_rst", 64'(aux_ready), 64'd0);
      idle();
      after_edge();
      check("t6_ready", 64'(aux_ready), 64'd1);
      check("t6_no_stale", 64'(rf_wr_en), 64'd0);

      // Randomized traffic with varying write-back pressure
      for (int i = 0; i < 3000; i++) begin
         int unsigned wbp;
         wbp = (i / 500) % 3 == 0 ? 20 : ((i / 500) % 3 == 1 ? 60 : 90);
         step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < wbp, rand_addr(),
              $urandom(), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rand_addr(),
              $urandom(), 2'($urandom_range(0, 2)));
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
